mode_select_debounce: RTL and testbench

MODE_SELECT_DEBOUNCE -- requirements
Module: mode_select_debounce

---
 rtl/mode_sel_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/mode_select_debounce.sv | 120 ++++++++++++
 tb/tb_mode_select_debounce.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mode_sel_pkg.sv
// Shared mode-select definitions: debounce FSM encoding, default constants, mode wrap helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mode_sel_pkg;

    // 20 ms at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_NUM_MODES       = 4;
    localparam int MODE_W              = 2;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

    // Advance the mode index, wrapping from num_modes-1 back to 0 so an
    // out-of-range select can never reach the clock-divider mux.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                    input int               num_modes);
        if (int'(cur) >= num_modes - 1) begin
            return '0;
        end
        return cur + MODE_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous board input into the clk domain.
// Latency: 2 clk edges from input to output.
// Backpressure: none; samples every cycle.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mode_select_debounce.sv
// Debounces a push-button and steps a mode index once per accepted press.
// Latency: mode_change rises DEBOUNCE_CYCLES+2 edges after btn first goes high.
// Backpressure: none; every outcome is registered, no auto-repeat while held.
module mode_select_debounce
    import mode_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NUM_MODES       = DEF_NUM_MODES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn,
    output logic [MODE_W-1:0] mode,
    output logic              mode_change,
    output logic              btn_level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic              w_btn_s;
    db_state_t         r_state;
    db_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] w_mode_nxt;
    logic              r_mode_change;
    logic              w_mode_change_nxt;
    logic              r_btn_level;
    logic              w_btn_level_nxt;

    sync_2ff u_sync_btn (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (btn),
        .o_q     (w_btn_s)
    );

    // Debounce FSM: a level is accepted only after DEBOUNCE_CYCLES identical samples.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_mode_nxt        = r_mode;
        w_mode_change_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_btn_s) begin
                    // bounce: drop the partial count, mode untouched
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt       = ST_PRESSED;
                    w_cnt_nxt         = '0;
                    w_mode_nxt        = next_mode(r_mode, NUM_MODES);
                    w_mode_change_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                // holding never re-triggers; only a release moves us on
                if (!w_btn_s) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_btn_s) begin
                    // release glitch: still pressed, no new increment
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_btn_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
    end

    // State and all outputs registered so the mux select never glitches between edges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_mode        <= '0;
            r_mode_change <= 1'b0;
            r_btn_level   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_mode        <= w_mode_nxt;
            r_mode_change <= w_mode_change_nxt;
            r_btn_level   <= w_btn_level_nxt;
        end
    end

    assign mode        = r_mode;
    assign mode_change = r_mode_change;
    assign btn_level   = r_btn_level;

endmodule

// File: tb/tb_mode_select_debounce.sv
// Bench for mode_select_debounce: directed press/bounce/wrap/reset scenarios plus random button runs.
// Two instances (4 modes and 3 modes) share the stimulus; a run-length model predicts every cycle.
// Inputs driven 1 time unit after each rising edge, outputs sampled at that same point.
module tb_mode_select_debounce;

    localparam int D = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       btn   = 1'b0;
    logic [1:0] mode4;
    logic [1:0] mode3;
    logic       mc4;
    logic       mc3;
    logic       lvl4;
    logic       lvl3;

    mode_select_debounce #(.DEBOUNCE_CYCLES(D), .NUM_MODES(4)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .mode        (mode4),
        .mode_change (mc4),
        .btn_level   (lvl4)
    );

    mode_select_debounce #(.DEBOUNCE_CYCLES(D), .NUM_MODES(3)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .mode        (mode3),
        .mode_change (mc3),
        .btn_level   (lvl3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: debounced level flips after D consecutive synchronized
    // samples disagreeing with it; each 0->1 flip advances mode modulo N.
    int m_s1[2];
    int m_s2[2];
    int m_lvl[2];
    int m_run[2];
    int m_mode[2];
    int m_pulse[2];
    int nm[2] = '{4, 3};

    int pulses4   = 0;
    int pulses3   = 0;
    bit seen_bad3 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
                m_run[i] = 0; m_mode[i] = 0; m_pulse[i] = 0;
            end else begin
                m_pulse[i] = 0;
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = 1 - m_lvl[i];
                        m_run[i] = 0;
                        if (m_lvl[i] == 1) begin
                            m_mode[i]  = (m_mode[i] + 1) % nm[i];
                            m_pulse[i] = 1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(btn);
            end
        end
    endtask

    // One clock cycle: drive, let the edge happen, advance model, compare.
    task automatic tick(input logic b, input logic r);
        btn   = b;
        reset = r;
        @(posedge clk);
        model_edge();
        #1;
        if (mc4) pulses4++;
        if (mc3) pulses3++;
        if (mode3 >= 2'd3) seen_bad3 = 1'b1;
        chk("mode_n4",  32'(mode4), 32'(m_mode[0]));
        chk("pulse_n4", 32'(mc4),   32'(m_pulse[0]));
        chk("level_n4", 32'(lvl4),  32'(m_lvl[0]));
        chk("mode_n3",  32'(mode3), 32'(m_mode[1]));
        chk("pulse_n3", 32'(mc3),   32'(m_pulse[1]));
        chk("level_n3", 32'(lvl3),  32'(m_lvl[1]));
    endtask

    int   pk;
    bit   flag;
    int   exp4[4] = '{1, 2, 3, 0};
    int   exp3[4] = '{1, 2, 0, 1};
    int   len;
    logic lv;

    initial begin
        // reset state
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_mode",  32'(mode4), 32'd0);
        chk("rst_pulse", 32'(mc4),   32'd0);
        chk("rst_level", 32'(lvl4),  32'd0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);

        // clean press held 40 cycles: pulse on the (D+2)th edge after btn rises
        pulses4 = 0;
        pk = -1;
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1, 1'b1);
            if (mc4 && pk < 0) pk = k;
        end
        chk("press_latency", 32'(pk),      32'(D + 2));
        chk("press_pulses",  32'(pulses4), 32'd1);
        chk("press_mode",    32'(mode4),   32'd1);
        chk("press_level",   32'(lvl4),    32'd1);
        for (int k = 0; k < 12; k++) tick(1'b0, 1'b1);
        chk("release_level", 32'(lvl4), 32'd0);

        // bounce: toggle every 3 cycles for 30 cycles, then low
        tick(1'b0, 1'b0);
        pulses4 = 0;
        flag = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick((k < 30) && (((k / 3) % 2) == 0), 1'b1);
            if (lvl4) flag = 1'b1;
        end
        chk("bounce_pulses", 32'(pulses4), 32'd0);
        chk("bounce_mode",   32'(mode4),   32'd0);
        chk("bounce_level",  32'(flag),    32'd0);

        // wrap: four clean presses on both instances
        tick(1'b0, 1'b0);
        pulses4 = 0;
        pulses3 = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 12; k++) tick(1'b1, 1'b1);
            chk("wrap_mode_n4", 32'(mode4), 32'(exp4[p]));
            chk("wrap_mode_n3", 32'(mode3), 32'(exp3[p]));
            for (int k = 0; k < 12; k++) tick(1'b0, 1'b1);
        end
        chk("wrap_pulses_n4", 32'(pulses4), 32'd4);
        chk("wrap_pulses_n3", 32'(pulses3), 32'd4);

        // release bounce: 1-cycle high glitch every 4 cycles after an accepted press
        tick(1'b0, 1'b0);
        pulses4 = 0;
        for (int k = 0; k < 12; k++) tick(1'b1, 1'b1);
        flag = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick((k % 4) == 3, 1'b1);
            if (!lvl4) flag = 1'b1;
        end
        chk("relbounce_held",   32'(flag),    32'd0);
        for (int k = 0; k < 12; k++) tick(1'b0, 1'b1);
        chk("relbounce_pulses", 32'(pulses4), 32'd1);
        chk("relbounce_mode",   32'(mode4),   32'd1);
        chk("relbounce_level",  32'(lvl4),    32'd0);

        // reset mid-debounce with the button still held
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        chk("midrst_mode", 32'(mode4), 32'd0);
        pulses4 = 0;
        pk = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, 1'b1);
            if (mc4 && pk < 0) pk = k;
        end
        chk("midrst_latency", 32'(pk),      32'(D + 2));
        chk("midrst_mode1",   32'(mode4),   32'd1);
        chk("midrst_pulses",  32'(pulses4), 32'd1);
        for (int k = 0; k < 12; k++) tick(1'b0, 1'b1);

        // random button runs with occasional resets
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 29) == 0) tick(1'b0, 1'b0);
            lv  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            for (int j = 0; j < len; j++) tick(lv, 1'b1);
        end

        chk("n3_never_mode3", 32'(seen_bad3), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
